// File: rtl/afe_frame_serializer_if.sv
// Host/serial-side bundle of afe_frame_serializer.
//   master: host side. It drives the store write port, start and cont, and
//           observes the four serial lanes plus busy/done.
//   slave : serializer side.
// Signals: wr_en, wr_axis (0=y,1=x), wr_index[6:0], wr_data[15:0], start, cont,
//          bit1..bit4 (serial lanes), busy, done.
interface afe_frame_serializer_if;
  logic        wr_en;
  logic        wr_axis;
  logic [6:0]  wr_index;
  logic [15:0] wr_data;
  logic        start;
  logic        cont;
  logic        bit1;
  logic        bit2;
  logic        bit3;
  logic        bit4;
  logic        busy;
  logic        done;

  modport master (
    output wr_en, wr_axis, wr_index, wr_data, start, cont,
    input  bit1, bit2, bit3, bit4, busy, done
  );

  modport slave (
    input  wr_en, wr_axis, wr_index, wr_data, start, cont,
    output bit1, bit2, bit3, bit4, busy, done
  );
endinterface

// File: rtl/afe_frame_serializer.sv
// afe_frame_serializer: transmit end of the AFE-to-aggregator serial protocol.
// Holds one image line (128 y + 128 x samples of 16 bits), written through a
// host port. On start it sends 64 frames on each of four lanes in lockstep.
// Each frame is: start bit 1, channel bit, data[15:0] MSB first, and then
// GAP_CYCLES idle-low cycles.
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   bus.slave  wr_en/wr_axis/wr_index/wr_data (store write, dropped while busy),
//              start, cont, bit1..bit4 (registered lanes), busy, done (1-cycle)
// Parameter: GAP_CYCLES (1..15) sets the idle-low cycles after each frame.
// Optional feature: define AFE_TX_CONT_EN to turn on continuous mode. In that
// mode, cont=1 in the last gap cycle restarts the burst at frame 0 with no
// idle cycle.
module afe_frame_serializer #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  afe_frame_serializer_if.slave bus
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DEPTH    = 128;
  localparam int unsigned IDX_W    = 7;
  localparam int unsigned K_W      = 6;
  localparam int unsigned BIT_W    = 4;
  localparam int unsigned GAP_W    = 4;
  localparam int unsigned LANES    = 4;

  localparam logic [K_W-1:0]   LAST_FRAME = K_W'(63);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CHAN,
    S_DATA,
    S_GAP
  } state_t;

  // State names the symbol currently on the lanes. The lane bits are
  // registered in the same edge that enters the state.
  state_t                            state_q, state_d;
  logic [K_W-1:0]                    k_q, k_d;
  logic [BIT_W-1:0]                  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]                  gap_cnt_q, gap_cnt_d;
  logic [LANES-1:0][SAMPLE_W-1:0]    sr_q, sr_d;
  logic [LANES-1:0]                  lane_q, lane_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;

  logic [SAMPLE_W-1:0]               y_mem [DEPTH];
  logic [SAMPLE_W-1:0]               x_mem [DEPTH];

  // Sample store. It is frozen while a burst runs, so a burst sends the line
  // it started with.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        y_mem[i] <= '0;
        x_mem[i] <= '0;
      end
    end else if (bus.wr_en && !busy_q) begin
      if (bus.wr_axis) begin
        x_mem[bus.wr_index] <= bus.wr_data;
      end else begin
        y_mem[bus.wr_index] <= bus.wr_data;
      end
    end
  end

  // Frame k sends channel k[0] and index 31-k[5:1]. A lane's upper half of
  // the store differs from the lower half only in address bit 6.
  logic [K_W-1:0]   rd_addr_c;
  logic [IDX_W-1:0] rd_lo_c;
  logic [IDX_W-1:0] rd_hi_c;

  assign rd_addr_c = {k_q[0], ~k_q[K_W-1:1]};
  assign rd_lo_c   = {1'b0, rd_addr_c};
  assign rd_hi_c   = {1'b1, rd_addr_c};

`ifndef AFE_TX_CONT_EN
  logic unused_cont;
  assign unused_cont = bus.cont;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sr_q      <= '0;
      lane_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sr_q      <= sr_d;
      lane_q    <= lane_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next state and the next symbol for each lane.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sr_d      = sr_q;
    lane_d    = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_START;
          k_d     = '0;
          lane_d  = '1;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        sr_d[0] = y_mem[rd_lo_c];
        sr_d[1] = y_mem[rd_hi_c];
        sr_d[2] = x_mem[rd_lo_c];
        sr_d[3] = x_mem[rd_hi_c];
        lane_d  = {LANES{k_q[0]}};
        state_d = S_CHAN;
      end

      S_CHAN: begin
        for (int l = 0; l < int'(LANES); l++) begin
          lane_d[l] = sr_q[l][SAMPLE_W-1];
          sr_d[l]   = {sr_q[l][SAMPLE_W-2:0], 1'b0};
        end
        bit_cnt_d = '1;
        state_d   = S_DATA;
      end

      S_DATA: begin
        if (bit_cnt_q != '0) begin
          for (int l = 0; l < int'(LANES); l++) begin
            lane_d[l] = sr_q[l][SAMPLE_W-1];
            sr_d[l]   = {sr_q[l][SAMPLE_W-2:0], 1'b0};
          end
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end else begin
          gap_cnt_d = GAP_LOAD;
          state_d   = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else if (k_q != LAST_FRAME) begin
          k_d     = k_q + K_W'(1);
          lane_d  = '1;
          state_d = S_START;
        end else begin
          done_d = 1'b1;
          k_d    = '0;
`ifdef AFE_TX_CONT_EN
          if (bus.cont) begin
            lane_d  = '1;
            state_d = S_START;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.bit1 = lane_q[0];
  assign bus.bit2 = lane_q[1];
  assign bus.bit3 = lane_q[2];
  assign bus.bit4 = lane_q[3];
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_afe_frame_serializer.sv
// Self-checking bench for afe_frame_serializer. It fills the store with random
// samples, runs bursts, and compares every lane/busy/done cycle against
// waveforms computed arithmetically from the frame layout.
module tb_afe_frame_serializer;

  localparam int G  = 2;
  localparam int FL = 18 + G;
  localparam int B  = 64 * FL;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  afe_frame_serializer_if bus ();

  afe_frame_serializer #(.GAP_CYCLES(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] y_m [128];
  logic [15:0] x_m [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 128; i++) begin
      y_m[i] = 16'h0000;
      x_m[i] = 16'h0000;
    end
  endfunction

  // Expected {bit4,bit3,bit2,bit1} at cycle offset off after the start sample.
  function automatic logic [3:0] exp_lanes(input int off, input int nb);
    logic [3:0]  r;
    logic [15:0] s;
    int rel, k, p, ch, addr;
    r = 4'b0000;
    if (off < 1 || off > nb * B) return r;
    rel  = (off - 1) % B;
    k    = rel / FL;
    p    = rel % FL;
    ch   = k % 2;
    addr = ch * 32 + (31 - k / 2);
    for (int l = 0; l < 4; l++) begin
      case (l)
        0:       s = y_m[addr];
        1:       s = y_m[addr + 64];
        2:       s = x_m[addr];
        default: s = x_m[addr + 64];
      endcase
      if (p == 0)      r[l] = 1'b1;
      else if (p == 1) r[l] = (ch == 1);
      else if (p < 18) r[l] = s[15 - (p - 2)];
      else             r[l] = 1'b0;
    end
    return r;
  endfunction

  task automatic do_write(input logic axis, input int idx, input logic [15:0] data);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_axis  = axis;
    bus.wr_index = 7'(idx);
    bus.wr_data  = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (axis) x_m[idx] = data;
    else      y_m[idx] = data;
  endtask

  // Starts a burst and checks every cycle. The optional stimulus offsets
  // (-1 = unused) inject: a dropped write y[5]=FFFF, a mid-burst reset,
  // a stray start pulse, and the cycle where cont is released.
  task automatic run_burst(input int nb, input int wr_off, input int rst_off,
                           input int start_off, input int cont_clr_off);
    @(negedge clk);
    bus.start = 1'b1;
    for (int off = 1; off <= nb * B + 2; off++) begin
      @(negedge clk);
      check("lanes", 32'({bus.bit4, bus.bit3, bus.bit2, bus.bit1}), 32'(exp_lanes(off, nb)));
      check("busy", 32'(bus.busy), 32'(off <= nb * B));
      check("done", 32'(bus.done), 32'((off > 1) && ((off - 1) % B == 0)));
      if (off == rst_off) begin
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("rst_lanes", 32'({bus.bit4, bus.bit3, bus.bit2, bus.bit1}), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        reset = 1'b0;
        model_clear();
        break;
      end
      bus.start    = (off == start_off);
      bus.wr_en    = (off == wr_off);
      bus.wr_axis  = 1'b0;
      bus.wr_index = 7'd5;
      bus.wr_data  = 16'hFFFF;
      if (off == cont_clr_off) bus.cont = 1'b0;
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_axis  = 1'b0;
    bus.wr_index = 7'd0;
    bus.wr_data  = 16'h0000;
    bus.start    = 1'b0;
    bus.cont     = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_lanes", 32'({bus.bit4, bus.bit3, bus.bit2, bus.bit1}), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_done", 32'(bus.done), 32'(0));

    // All-zero store: only start bits and odd-frame channel bits appear.
    run_burst(1, -1, -1, -1, -1);

    // Single known sample on bit1 frame 0; a stray start mid-burst is ignored.
    do_write(1'b0, 31, 16'hA5C3);
    run_burst(1, -1, -1, 600, -1);

    // Random line; a write during the burst must be dropped.
    for (int i = 0; i < 128; i++) begin
      do_write(1'b0, i, 16'($urandom));
      do_write(1'b1, i, 16'($urandom));
    end
    run_burst(1, 300, -1, -1, -1);
    repeat (2) @(negedge clk);
    run_burst(1, -1, -1, -1, -1);

    // Reset mid-burst clears everything; the next burst starts cleanly.
    run_burst(1, -1, 700, -1, -1);
    for (int i = 0; i < 16; i++) begin
      do_write(1'($urandom), int'($urandom_range(0, 127)), 16'($urandom));
    end
    run_burst(1, -1, -1, -1, -1);

    // Continuous request: back-to-back bursts when enabled, ignored otherwise.
    bus.cont = 1'b1;
`ifdef AFE_TX_CONT_EN
    run_burst(2, -1, -1, -1, B + 10);
`else
    run_burst(1, -1, -1, -1, -1);
`endif
    bus.cont = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/afe_frame_serializer.md
# afe_frame_serializer

Drives the four AFE serial lines (`bit1`..`bit4`) with framed 16-bit samples, i.e. the transmit end of the AFE-to-aggregator serial protocol. It holds one full image line (128 y-axis + 128 x-axis samples) written by a host port, and on `start` emits 64 frames per lane in lockstep. The order is chosen so that a downstream aggregator fills all four 32-sample slots of each axis and asserts its `finished` flag. It is used as the AFE emulator for loopback bring-up and as a bench stimulus source.

## Interface
- `GAP_CYCLES`, 2, idle-low cycles after each frame's last data bit; legal range 1..15.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write strobe into the sample store.
- `wr_axis`  in  1  0 = y-axis store, 1 = x-axis store.
- `wr_index`  in  7  sample index 0..127.
- `wr_data`  in  16  sample value.
- `start`  in  1  begin a burst; single-cycle pulse or level.
- `cont`  in  1  continuous-mode request; see Configuration.
- `bit1`..`bit4`  out  1 each  serial lanes, registered.
- `busy`  out  1  burst in progress.
- `done`  out  1  one-cycle pulse at burst end.

## Operation
- Store: two 128x16 register arrays, cleared to 0 on reset.
  - A write is accepted only when `busy`=0. Writes while `busy`=1 are dropped.
- Frame on each lane: start bit 1, then channel bit, then data[15] down to data[0], then `GAP_CYCLES` cycles of 0.
  - Length is 18+`GAP_CYCLES` cycles.
  - Idle level is 0.
- Lane mapping, for frame k = 0..63, with ch = k[0] and idx = 31 - k[5:1]:
  - `bit1` sends y[ch*32+idx].
  - `bit2` sends y[64+ch*32+idx].
  - `bit3` sends x[ch*32+idx].
  - `bit4` sends x[64+ch*32+idx].
  - The channel bit on every lane equals ch.
  - Frame 0 is channel 0, idx 31. Frame 63 is channel 1, idx 0.
- One shared FSM drives all four lanes.
  - IDLE: lanes 0. On `start`=1, go to START.
  - START: emit 1, load four 16-bit shift registers from the store, go to CHAN.
  - CHAN: emit ch, go to DATA with bit counter 15.
  - DATA: emit the shift-register MSB; after counter reaches 0, go to GAP.
  - GAP: emit 0 for `GAP_CYCLES` cycles.
    - If k<63: k+1, go to START.
    - If k=63: go to IDLE and pulse `done`.
- Frame counter k is 6 bits and bit counter is 4 bits; no wrap occurs inside a burst.
- `start` during a burst is ignored (not queued).
- Reset mid-burst: next cycle all lanes 0, `busy`=0, `done`=0, k=0, store cleared.

## Timing
- Reset values: `bit1`..`bit4`=0, `busy`=0, `done`=0.
- `start` sampled high at cycle T in IDLE:
  - `busy`=1 from T+1.
  - Start bit on lanes at T+1, channel bit at T+2, data[15..0] at T+3..T+18.
  - Gap at T+19..T+18+`GAP_CYCLES`.
- Frame k start bit is at T+1+k*(18+`GAP_CYCLES`).
- Burst length is B = 64*(18+`GAP_CYCLES`) cycles.
  - At T+1+B: `busy`=0 and `done`=1 for exactly one cycle.
  - With `done`, `start` is sampled again at T+1+B at the earliest, so burst-to-burst spacing is ≥1 idle cycle.
- Store contents are read at each START cycle; the burst sends what was stored when it began, since writes are blocked.

## Configuration
- `AFE_TX_CONT_EN` defined: if `cont`=1 in the final GAP cycle of frame 63, go directly to START with k=0.
  - `done` still pulses for one cycle at that point.
  - `busy` stays 1.
  - Writes remain blocked until `cont`=0 lets the burst end.
- Not defined: `cont` is ignored and every burst ends in IDLE.

## Test plan
- Reset, then `start` with store all zeros, `GAP_CYCLES`=2:
  - Each lane shows a 1 at T+1 and T+1+20, and 0 elsewhere except the channel bit 1 on odd frames.
  - `done` pulses at T+1281.
- Write y[31]=0xA5C3, then `start`:
  - `bit1` frame 0 is 1,0,1010010111000011,0,0.
  - `bit2`..`bit4` frame 0 data is 0x0000.
- Fill y[i]=i, x[i]=0x100+i and connect to the aggregator:
  - Its `finished`=1 after `done`.
  - Readback of y[i] and x[i] matches for all 0..127.
- `wr_en` with y[5]=0xFFFF during a burst:
  - The write is dropped, y[5] is unchanged, and a second burst still sends the old value.
- `reset` at cycle T+700 of a burst: lanes 0 and `busy`=0 from T+701; a new `start` begins cleanly at frame 0.
- With `AFE_TX_CONT_EN` and `cont`=1:
  - Two back-to-back bursts with no idle cycle.
  - `done` pulses at T+1281 while `busy` stays 1.
  - The second frame-0 start bit is at T+1281.
